uart_rx_deframe: RTL and testbench

//  Receive-side deframer of the full-duplex UART core. Sits directly downstream of the rx SIPO.

---
 rtl/uart_rx_deframe.sv | 126 ++++++++++++
 tb/tb_uart_rx_deframe.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deframe.sv
// Receive deframer: captures SIPO frames on the rising edge of def_en, checks start/stop/parity,
// and queues {frame_err, parity_err, data} into a show-ahead FIFO read by the host.
module uart_rx_deframe #(
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic             baud_clk,
  input  logic             rstn,
  input  logic [10:0]      frame_in,
  input  logic             def_en,
  input  logic             rd_en,
  input  logic             err_clr,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             parity_err,
  output logic             break_det,
  output logic             overrun,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int AW = CNT_W - 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CAPT = 2'd1;
  localparam logic [1:0] PUSH = 2'd2;

  logic [1:0]    state;
  logic          def_en_q;
  logic [10:0]   frame_reg;
  logic          fe_q;
  logic          pe_q;
  logic          brk_q;
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [9:0]    head;
  logic          def_evt;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  assign def_evt = def_en & ~def_en_q;
  assign full    = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign pop     = rd_en & rx_valid;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept the push.
  assign push    = (state == PUSH) & (~full | pop);
  assign drop    = (state == PUSH) & full & ~pop;

  always_ff @(posedge baud_clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      def_en_q  <= 1'b0;
      frame_reg <= 11'd0;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      def_en_q <= def_en;
      case (state)
        IDLE: begin
          if (def_evt) begin
            frame_reg <= frame_in;
            state     <= CAPT;
          end
        end
        CAPT: begin
          fe_q  <= (frame_reg[0] != 1'b0) | (frame_reg[10] != 1'b1);
          pe_q  <= PARITY_EN & ((^frame_reg[9:1]) != PARITY_ODD);
          brk_q <= (frame_reg == 11'd0);
          state <= PUSH;
        end
        PUSH:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge baud_clk) begin
    if (push) begin
      mem[wr_ptr] <= {fe_q, pe_q, frame_reg[8:1]};
    end
  end

  always_ff @(posedge baud_clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Setting outranks err_clr so a drop in the clearing cycle is never lost.
  always_ff @(posedge baud_clk or negedge rstn) begin
    if (!rstn) begin
      overrun <= 1'b0;
    end else if ((def_evt && (state != IDLE)) || drop) begin
      overrun <= 1'b1;
    end else if (err_clr) begin
      overrun <= 1'b0;
    end
  end

  assign head       = mem[rd_ptr];
  assign rx_valid   = (fifo_count != '0);
  assign rx_data    = rx_valid ? head[7:0] : 8'h00;
  assign frame_err  = rx_valid & head[9];
  assign parity_err = rx_valid & head[8];
  assign break_det  = (state == PUSH) & brk_q;

endmodule

// File: tb/tb_uart_rx_deframe.sv
// Bench for uart_rx_deframe: vector table plus scoreboard queue of expected FIFO entries,
// with hand-written sequences for overflow, simultaneous push/pop, held strobe and mid-frame reset.
module tb_uart_rx_deframe;

  logic        baud_clk;
  logic        rstn;
  logic [10:0] frame_in;
  logic        def_en;
  logic        rd_en;
  logic        err_clr;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        parity_err;
  logic        break_det;
  logic        overrun;
  logic [2:0]  fifo_count;

  logic [7:0]  np_rx_data;
  logic        np_rx_valid;
  logic        np_frame_err;
  logic        np_parity_err;
  logic        np_break_det;
  logic        np_overrun;
  logic [2:0]  np_fifo_count;

  uart_rx_deframe #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0), .FIFO_DEPTH(4), .CNT_W(3)) dut (
    .baud_clk(baud_clk), .rstn(rstn), .frame_in(frame_in), .def_en(def_en),
    .rd_en(rd_en), .err_clr(err_clr), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err), .parity_err(parity_err), .break_det(break_det),
    .overrun(overrun), .fifo_count(fifo_count)
  );

  // Parity-disabled twin sees identical stimulus; only its parity flag differs.
  uart_rx_deframe #(.PARITY_EN(1'b0), .PARITY_ODD(1'b0), .FIFO_DEPTH(4), .CNT_W(3)) dut_np (
    .baud_clk(baud_clk), .rstn(rstn), .frame_in(frame_in), .def_en(def_en),
    .rd_en(rd_en), .err_clr(err_clr), .rx_data(np_rx_data), .rx_valid(np_rx_valid),
    .frame_err(np_frame_err), .parity_err(np_parity_err), .break_det(np_break_det),
    .overrun(np_overrun), .fifo_count(np_fifo_count)
  );

  initial baud_clk = 1'b0;
  always #5 baud_clk = ~baud_clk;

  typedef struct {
    logic [10:0] frame;
    logic [7:0]  data;
    logic        fe;
    logic        pe;
    logic        brk;
  } vec_t;

  vec_t        vecs [7];
  logic [9:0]  exp_q [$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic tick();
    @(posedge baud_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected FIFO entry for an even-parity, parity-enabled receiver.
  function automatic logic [9:0] expect_entry(input logic [10:0] f);
    logic fe;
    logic pe;
    fe = (f[0] != 1'b0) | (f[10] != 1'b1);
    pe = ^f[9:1];
    return {fe, pe, f[8:1]};
  endfunction

  // One-cycle def_en pulse; returns just after the capture edge (FSM in CAPT).
  task automatic applyStimulus(input logic [10:0] f);
    frame_in = f;
    def_en   = 1'b1;
    tick();
    def_en   = 1'b0;
  endtask

  task automatic checkOutput(input string name);
    logic [9:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q[0];
      check({name, "_valid"}, 32'(rx_valid), 32'd1);
      check({name, "_data"}, 32'(rx_data), 32'(e[7:0]));
      check({name, "_fe"}, 32'(frame_err), 32'(e[9]));
      check({name, "_pe"}, 32'(parity_err), 32'(e[8]));
    end
  endtask

  task automatic pop_entry();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_count"}, 32'(fifo_count), 32'd0);
    check({name, "_valid"}, 32'(rx_valid), 32'd0);
    check({name, "_data"}, 32'(rx_data), 32'd0);
    check({name, "_fe"}, 32'(frame_err), 32'd0);
    check({name, "_pe"}, 32'(parity_err), 32'd0);
    check({name, "_brk"}, 32'(break_det), 32'd0);
    check({name, "_ovr"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [10:0] t4f [5];
    logic [10:0] t5f [4];

    vecs[0] = '{frame: 11'h4AA, data: 8'h55, fe: 1'b0, pe: 1'b0, brk: 1'b0};
    vecs[1] = '{frame: 11'h6AA, data: 8'h55, fe: 1'b0, pe: 1'b1, brk: 1'b0};
    vecs[2] = '{frame: 11'h0AA, data: 8'h55, fe: 1'b1, pe: 1'b0, brk: 1'b0};
    vecs[3] = '{frame: 11'h000, data: 8'h00, fe: 1'b1, pe: 1'b0, brk: 1'b1};
    vecs[4] = '{frame: 11'h74E, data: 8'hA7, fe: 1'b0, pe: 1'b0, brk: 1'b0};
    vecs[5] = '{frame: 11'h602, data: 8'h01, fe: 1'b0, pe: 1'b0, brk: 1'b0};
    vecs[6] = '{frame: 11'h4AB, data: 8'h55, fe: 1'b1, pe: 1'b0, brk: 1'b0};
    t4f = '{11'h74E, 11'h4AA, 11'h602, 11'h6AA, 11'h0AA};
    t5f = '{11'h4AA, 11'h74E, 11'h602, 11'h0AA};

    rstn     = 1'b0;
    frame_in = 11'd0;
    def_en   = 1'b0;
    rd_en    = 1'b0;
    err_clr  = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].frame);
      exp_q.push_back({vecs[i].fe, vecs[i].pe, vecs[i].data});
      tick();
      check($sformatf("v%0d_brk", i), 32'(break_det), 32'(vecs[i].brk));
      check($sformatf("v%0d_latency_valid", i), 32'(rx_valid), 32'd0);
      tick();
      checkOutput($sformatf("v%0d", i));
      check($sformatf("v%0d_count", i), 32'(fifo_count), 32'd1);
      check($sformatf("v%0d_brk_off", i), 32'(break_det), 32'd0);
      check($sformatf("v%0d_np_pe", i), 32'(np_parity_err), 32'd0);
      check($sformatf("v%0d_np_data", i), 32'(np_rx_data), 32'(vecs[i].data));
      pop_entry();
      check($sformatf("v%0d_empty_data", i), 32'(rx_data), 32'd0);
    end

    for (int i = 0; i < 5; i++) begin
      applyStimulus(t4f[i]);
      tick();
      tick();
      if (exp_q.size() < 4) exp_q.push_back(expect_entry(t4f[i]));
    end
    check("t4_count", 32'(fifo_count), 32'd4);
    check("t4_overrun", 32'(overrun), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4_clr", 32'(overrun), 32'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t4_rd%0d", i));
      pop_entry();
    end
    check("t4_drained", 32'(fifo_count), 32'd0);

    applyStimulus(11'h4AA);
    tick();
    def_en  = 1'b1;
    err_clr = 1'b1;
    tick();
    def_en  = 1'b0;
    err_clr = 1'b0;
    exp_q.push_back(expect_entry(11'h4AA));
    check("setwins_ovr", 32'(overrun), 32'd1);
    check("setwins_count", 32'(fifo_count), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("setwins_clr", 32'(overrun), 32'd0);
    checkOutput("setwins_entry");
    pop_entry();

    for (int i = 0; i < 4; i++) begin
      applyStimulus(t5f[i]);
      tick();
      tick();
      exp_q.push_back(expect_entry(t5f[i]));
    end
    check("t5_full", 32'(fifo_count), 32'd4);
    applyStimulus(11'h6AA);
    tick();
    checkOutput("t5_head");
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(expect_entry(11'h6AA));
    check("t5_no_ovr", 32'(overrun), 32'd0);
    check("t5_count", 32'(fifo_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t5_rd%0d", i));
      pop_entry();
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("t5_empty_rd_count", 32'(fifo_count), 32'd0);
    check("t5_empty_rd_valid", 32'(rx_valid), 32'd0);

    frame_in = 11'h4AA;
    def_en   = 1'b1;
    repeat (10) tick();
    def_en = 1'b0;
    repeat (3) tick();
    exp_q.push_back(expect_entry(11'h4AA));
    check("t6_hold_count", 32'(fifo_count), 32'd1);
    checkOutput("t6_hold");
    pop_entry();
    check("t6_hold_drained", 32'(fifo_count), 32'd0);

    applyStimulus(11'h74E);
    tick();
    tick();
    check("t6_pre_count", 32'(fifo_count), 32'd1);
    applyStimulus(11'h4AA);
    rstn = 1'b0;
    #1;
    check_all_zero("t6_rst");
    exp_q.delete();
    tick();
    rstn = 1'b1;
    repeat (4) tick();
    check("t6_post_count", 32'(fifo_count), 32'd0);
    check("t6_post_valid", 32'(rx_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
